// File: rtl/qe_sample_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : qe_sample_scheduler_if
// Description : Snapshot handshake bundle between the sample scheduler and a
//               bank of quadrature-encoder channels.
//               snap_req  - one-hot request, scheduler -> channel i
//               snap_ack  - channel i acknowledge, snap_data valid same cycle
//               snap_data - flattened counts, channel i at [32i+31:32i]
// Revision    : 1.0 - initial release
// ============================================================================
interface qe_sample_scheduler_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]    snap_req;
    logic [NUM_CH-1:0]    snap_ack;
    logic [NUM_CH*32-1:0] snap_data;

    // Scheduler side
    modport master (
        output snap_req,
        input  snap_ack,
        input  snap_data
    );

    // Encoder-channel side
    modport slave (
        input  snap_req,
        output snap_ack,
        output snap_data
    );
endinterface
`default_nettype wire

// File: rtl/qe_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : qe_sample_scheduler
// Description : Periodic snapshot sequencer for NUM_CH quadrature-encoder
//               channels. Each sweep walks channels 0..NUM_CH-1, fetches a
//               count over the snap handshake and stores position plus the
//               signed delta against the previous sweep.
// Ports       : clk, reset (async, active-low)
//               enable, sample_period, sw_trigger, clr_status - control
//               snap        - snapshot handshake (master modport)
//               rd_ch -> rd_pos / rd_delta / rd_valid - read port
//               busy, sweep_done, overrun, timeout_err - status
// Revision    : 1.0 - initial release
// ============================================================================
module qe_sample_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 enable,
    input  wire logic [31:0]          sample_period,
    input  wire logic                 sw_trigger,
    input  wire logic                 clr_status,
    qe_sample_scheduler_if.master     snap,
    input  wire logic [2:0]           rd_ch,
    output logic      [31:0]          rd_pos,
    output logic      [31:0]          rd_delta,
    output logic                      rd_valid,
    output logic                      busy,
    output logic                      sweep_done,
    output logic                      overrun,
    output logic      [NUM_CH-1:0]    timeout_err
);
    localparam int                CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int                WAIT_W   = $clog2(TIMEOUT);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_STORE = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [CH_W-1:0]     ch, ch_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic                ch_timeout;
    logic [31:0]         cap;
    logic [31:0]         period_cnt;
    logic                enable_q;
    logic                tick;
    logic                start;
    logic                ack_sel;
    logic [31:0]         data_sel;
    logic [NUM_CH-1:0]   terr_set;
    logic [31:0]         pos   [NUM_CH];
    logic [31:0]         delta [NUM_CH];
    // valid doubles as the "seen" marker: both are set by the first store
    // and only cleared by reset.
    logic [NUM_CH-1:0]   valid;

    // ---------------------------------------------------------------- period
    // A low-to-high enable transition reloads instead of ticking, so the
    // first tick after enabling arrives sample_period cycles later.
    assign tick = enable && enable_q && (sample_period != 32'd0) && (period_cnt == 32'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_cnt <= '0;
            enable_q   <= 1'b0;
        end else begin
            enable_q <= enable;
            if (!enable || (sample_period == 32'd0))
                period_cnt <= '0;
            else if (!enable_q || (period_cnt == 32'd0))
                period_cnt <= sample_period - 32'd1;
            else
                period_cnt <= period_cnt - 32'd1;
        end
    end

    assign start = enable && (tick || sw_trigger);

    // -------------------------------------------------------- channel select
    always_comb begin
        ack_sel       = 1'b0;
        data_sel      = '0;
        snap.snap_req = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == CH_W'(i)) begin
                ack_sel          = snap.snap_ack[i];
                data_sel         = snap.snap_data[32*i +: 32];
                snap.snap_req[i] = (state == S_REQ);
            end
        end
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ch       <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ch       <= ch_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ch_nxt     = ch;
        wait_nxt   = wait_cnt;
        ch_timeout = 1'b0;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = S_REQ;
                        ch_nxt    = '0;
                        wait_nxt  = '0;
                    end
                end
                S_REQ: begin
                    // An ack in the last permitted cycle still counts.
                    if (ack_sel) begin
                        state_nxt = S_STORE;
                    end else if (wait_cnt == WAIT_MAX) begin
                        state_nxt  = S_NEXT;
                        ch_timeout = 1'b1;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
                S_STORE: state_nxt = S_NEXT;
                S_NEXT: begin
                    if (ch == LAST_CH) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_REQ;
                        ch_nxt    = ch + CH_W'(1);
                        wait_nxt  = '0;
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign busy       = (state != S_IDLE);
    assign sweep_done = (state == S_DONE);

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap   <= '0;
            valid <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pos[i]   <= '0;
                delta[i] <= '0;
            end
        end else begin
            if (enable && (state == S_REQ) && ack_sel)
                cap <= data_sel;
            if (enable && (state == S_STORE)) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch == CH_W'(i)) begin
                        // Modulo-2^32 subtraction gives the signed change
                        // across either wrap point.
                        delta[i] <= valid[i] ? (cap - pos[i]) : 32'd0;
                        pos[i]   <= cap;
                        valid[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- status
    always_comb begin
        terr_set = '0;
        for (int i = 0; i < NUM_CH; i++)
            terr_set[i] = ch_timeout && (ch == CH_W'(i));
    end

    // Set events take priority over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun     <= 1'b0;
            timeout_err <= '0;
        end else begin
            if (start && (state != S_IDLE))
                overrun <= 1'b1;
            else if (clr_status)
                overrun <= 1'b0;
            timeout_err <= terr_set | (clr_status ? '0 : timeout_err);
        end
    end

    // ------------------------------------------------------------- read port
    always_comb begin
        rd_pos   = '0;
        rd_delta = '0;
        rd_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == 3'(i)) begin
                rd_pos   = pos[i];
                rd_delta = delta[i];
                rd_valid = valid[i];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_qe_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_qe_sample_scheduler
// Description : Self-checking bench for qe_sample_scheduler. The bench plays
//               the encoder channels, keeps an arithmetic model of stored
//               position/delta, queues the expected result of each sweep and
//               a monitor compares them whenever sweep_done is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qe_sample_scheduler;
    localparam int NUM_CH  = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] sample_period = 32'd0;
    logic        sw_trigger = 1'b0;
    logic        clr_status = 1'b0;
    logic [2:0]  rd_ch;
    logic [2:0]  mon_rd_ch = 3'd0;
    logic [2:0]  main_rd_ch = 3'd0;
    logic        sb_reading = 1'b0;
    logic        sb_on = 1'b0;
    logic [31:0] rd_pos, rd_delta;
    logic        rd_valid, busy, sweep_done, overrun;
    logic [NUM_CH-1:0] timeout_err;

    assign rd_ch = sb_reading ? mon_rd_ch : main_rd_ch;

    qe_sample_scheduler_if #(.NUM_CH(NUM_CH)) sif ();

    qe_sample_scheduler #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_period(sample_period),
        .sw_trigger   (sw_trigger),
        .clr_status   (clr_status),
        .snap         (sif),
        .rd_ch        (rd_ch),
        .rd_pos       (rd_pos),
        .rd_delta     (rd_delta),
        .rd_valid     (rd_valid),
        .busy         (busy),
        .sweep_done   (sweep_done),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #10 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Channel behaviour: count to return, ack delay in cycles, never-ack mask
    logic [31:0]       cnts [NUM_CH];
    int                dly  [NUM_CH];
    logic [NUM_CH-1:0] never = '0;
    int                rq_cnt [NUM_CH];

    // Reference model of what the read port should hold
    logic [31:0]       m_pos   [NUM_CH];
    logic [31:0]       m_delta [NUM_CH];
    logic [NUM_CH-1:0] m_valid = '0;

    typedef struct packed {
        logic [NUM_CH-1:0][31:0] pos;
        logic [NUM_CH-1:0][31:0] delta;
        logic [NUM_CH-1:0]       valid;
        logic [NUM_CH-1:0]       terr;
        logic [31:0]             cycles;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int start_cyc = 0;
    logic busy_q = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // New count c for channel i as seen by a completed snapshot
    function automatic void apply(input int i, input logic [31:0] c);
        m_delta[i] = m_valid[i] ? (c - m_pos[i]) : 32'd0;
        m_pos[i]   = c;
        m_valid[i] = 1'b1;
    endfunction

    function automatic void apply_acked();
        for (int i = 0; i < NUM_CH; i++)
            if (!never[i]) apply(i, cnts[i]);
    endfunction

    // ---------------------------------------------------- channel responder
    always @(negedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            sif.snap_data[32*i +: 32] = cnts[i];
            if (sif.snap_req[i]) begin
                sif.snap_ack[i] = !never[i] && (rq_cnt[i] >= dly[i]);
                rq_cnt[i]++;
            end else begin
                sif.snap_ack[i] = 1'b0;
                rq_cnt[i] = 0;
            end
        end
    end

    always @(posedge clk) cyc++;

    // --------------------------------------------------------------- monitor
    always @(negedge clk) begin
        exp_t e;
        check32("req_onehot", 32'($onehot0(sif.snap_req)), 32'd1);
        if (busy && !busy_q) start_cyc = cyc;
        busy_q = busy;
        if (sb_on && sweep_done) begin
            if (exp_q.size() == 0) begin
                flag_fail("sb_unexpected_sweep_done");
            end else begin
                e = exp_q.pop_front();
                check32("sweep_cycles", 32'(cyc - start_cyc), e.cycles);
                check32("sb_timeout_err", 32'(timeout_err), 32'(e.terr));
                check32("sb_overrun", 32'(overrun), 32'd0);
                sb_reading = 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    mon_rd_ch = 3'(i);
                    #1;
                    check32($sformatf("sb_pos%0d", i), rd_pos, e.pos[i]);
                    check32($sformatf("sb_delta%0d", i), rd_delta, e.delta[i]);
                    check32($sformatf("sb_valid%0d", i), 32'(rd_valid), 32'(e.valid[i]));
                end
                mon_rd_ch = 3'(NUM_CH + $urandom_range(0, 7 - NUM_CH));
                #1;
                check32("oob_pos", rd_pos, 32'd0);
                check32("oob_delta", rd_delta, 32'd0);
                check32("oob_valid", 32'(rd_valid), 32'd0);
                sb_reading = 1'b0;
            end
        end
    end

    // ------------------------------------------------------- stimulus tasks
    task automatic set4(input logic [31:0] a, b, c, d);
        cnts[0] = a; cnts[1] = b; cnts[2] = c; cnts[3] = d;
        for (int i = 0; i < NUM_CH; i++) dly[i] = 0;
        never = '0;
    endtask

    task automatic run_sweep();
        exp_t e;
        int   n = 0;
        logic [31:0] cy = 0;
        @(negedge clk) clr_status = 1'b1;
        @(negedge clk) clr_status = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            cy += never[i] ? 32'(TIMEOUT + 1) : 32'(dly[i] + 3);
        apply_acked();
        for (int i = 0; i < NUM_CH; i++) begin
            e.pos[i]   = m_pos[i];
            e.delta[i] = m_delta[i];
        end
        e.valid  = m_valid;
        e.terr   = never;
        e.cycles = cy;
        exp_q.push_back(e);
        sw_trigger = 1'b1;
        @(negedge clk) sw_trigger = 1'b0;
        while (!sweep_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!sweep_done) flag_fail("sweep_done_wait");
        @(negedge clk);
    endtask

    task automatic check_ch_main(input int i);
        main_rd_ch = 3'(i);
        #1;
        check32($sformatf("pos%0d", i), rd_pos, m_pos[i]);
        check32($sformatf("delta%0d", i), rd_delta, m_delta[i]);
        check32($sformatf("valid%0d", i), 32'(rd_valid), 32'(m_valid[i]));
    endtask

    // ------------------------------------------------------------ main flow
    initial begin
        int  n;
        logic seen_done;
        for (int i = 0; i < NUM_CH; i++) begin
            m_pos[i] = '0; m_delta[i] = '0; rq_cnt[i] = 0;
        end
        set4(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        main_rd_ch = 3'd0;
        #1;
        check32("rst_snap_req", 32'(sif.snap_req), 32'd0);
        check32("rst_busy", 32'(busy), 32'd0);
        check32("rst_sweep_done", 32'(sweep_done), 32'd0);
        check32("rst_overrun", 32'(overrun), 32'd0);
        check32("rst_timeout_err", 32'(timeout_err), 32'd0);
        check_ch_main(0);
        check_ch_main(3);

        @(negedge clk) begin reset = 1'b1; enable = 1'b1; end
        @(negedge clk);
        sb_on = 1'b1;

        // Directed sweeps: first capture, signed deltas, both wrap points
        set4(32'd10, 32'd20, 32'd30, 32'd40);                      run_sweep();
        set4(32'd15, 32'd20, 32'd25, 32'hFFFF_FFFE);               run_sweep();
        set4(32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'd25, 32'hFFFF_FFFE); run_sweep();
        set4(32'd3, 32'h8000_0001, 32'd25, 32'hFFFF_FFFE);         run_sweep();

        // Random sweeps with varied ack delays and occasional missing acks
        for (int s = 0; s < 14; s++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnts[i]  = ($urandom_range(0, 3) != 0) ?
                           m_pos[i] + 32'($urandom_range(0, 2000)) - 32'd1000 : $urandom();
                dly[i]   = $urandom_range(0, 3);
                never[i] = ($urandom_range(0, 5) == 0);
            end
            run_sweep();
        end

        // Periodic ticks faster than a sweep with ch2 silent
        sb_on = 1'b0;
        set4(32'd100, 32'd200, 32'd300, 32'd400);
        never = 4'b0100;
        @(negedge clk) sample_period = 32'd10;
        n = 0;
        while (!sweep_done && n < 500) begin @(negedge clk); n++; end
        if (!sweep_done) flag_fail("periodic_sweep_wait");
        apply_acked();
        check32("per_timeout_err", 32'(timeout_err), 32'b0100);
        check32("per_overrun", 32'(overrun), 32'd1);
        for (int i = 0; i < NUM_CH; i++) check_ch_main(i);
        @(negedge clk) sample_period = 32'd0;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
            if (sweep_done) apply_acked();
        end
        if (busy) flag_fail("periodic_idle_wait");

        // clr_status alone clears; clear coinciding with an overrun loses
        @(negedge clk) clr_status = 1'b1;
        @(negedge clk) clr_status = 1'b0;
        check32("clr_overrun", 32'(overrun), 32'd0);
        check32("clr_timeout_err", 32'(timeout_err), 32'd0);
        never = '0;
        sw_trigger = 1'b1;
        @(negedge clk) sw_trigger = 1'b0;
        @(negedge clk) begin sw_trigger = 1'b1; clr_status = 1'b1; end
        @(negedge clk) begin sw_trigger = 1'b0; clr_status = 1'b0; end
        check32("clr_vs_overrun", 32'(overrun), 32'd1);
        n = 0;
        while (!sweep_done && n < 200) begin @(negedge clk); n++; end
        if (!sweep_done) flag_fail("clr_sweep_wait");
        apply_acked();
        @(negedge clk);

        // enable dropped while ch1 is being requested
        set4(32'd500, 32'd600, 32'd700, 32'd800);
        dly[1] = 5;
        @(negedge clk) sample_period = 32'd50;
        n = 0;
        while (!sif.snap_req[1] && n < 300) begin @(negedge clk); n++; end
        if (!sif.snap_req[1]) flag_fail("req1_wait");
        apply(0, cnts[0]);
        enable = 1'b0;
        @(negedge clk);
        check32("dis_snap_req", 32'(sif.snap_req), 32'd0);
        check32("dis_busy", 32'(busy), 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (sweep_done) seen_done = 1'b1;
        end
        check32("dis_no_sweep_done", 32'(seen_done), 32'd0);
        for (int i = 0; i < NUM_CH; i++) check_ch_main(i);
        enable = 1'b1;
        n = 0;
        while (!busy && n < 200) begin @(negedge clk); n++; end
        check32("reenable_tick_latency", 32'(n), 32'd51);
        sample_period = 32'd0;
        n = 0;
        while (!sweep_done && n < 200) begin @(negedge clk); n++; end
        if (!sweep_done) flag_fail("reenable_sweep_wait");
        apply_acked();
        @(negedge clk);

        // Asynchronous reset in the middle of a sweep
        set4(32'd7, 32'd8, 32'd9, 32'd10);
        dly[2] = 3;
        sw_trigger = 1'b1;
        @(negedge clk) sw_trigger = 1'b0;
        n = 0;
        while (!sif.snap_req[2] && n < 100) begin @(negedge clk); n++; end
        if (!sif.snap_req[2]) flag_fail("req2_wait");
        #3 reset = 1'b0;
        main_rd_ch = 3'd0;
        #1;
        check32("arst_snap_req", 32'(sif.snap_req), 32'd0);
        check32("arst_busy", 32'(busy), 32'd0);
        check32("arst_overrun", 32'(overrun), 32'd0);
        check32("arst_timeout_err", 32'(timeout_err), 32'd0);
        check32("arst_valid0", 32'(rd_valid), 32'd0);
        check32("arst_pos0", rd_pos, 32'd0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            m_pos[i] = '0; m_delta[i] = '0;
        end
        m_valid = '0;
        @(negedge clk);
        sb_on = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            cnts[i] = $urandom();
            dly[i]  = $urandom_range(0, 2);
        end
        never = '0;
        run_sweep();
        if (exp_q.size() != 0) flag_fail("sb_leftover_expectations");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire
